dds_wave_gen: RTL and testbench

Parametrised multi-mode DDS waveform generator. It is the successor of the single-mode ROM-lookup DDS core and is generalised in accumulator, address and data widths and external ROM latency. It adds sine, sawtooth, triangle and square modes, shadowed configuration with immediate or phase-wrap-synchronous update, phase clear, enable, and valid/wrap flags. It sits between the register/control logic and the DAC interface, and drives an external sine ROM.

---
 rtl/dds_wave_gen.sv | 205 ++++++++++++++++++++
 tb/tb_dds_wave_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_wave_gen.sv
// Multi-mode DDS waveform generator: phase accumulator with shadowed config,
// external sine ROM lookup and sawtooth/triangle/square synthesis.
module dds_wave_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 10,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              acc_clr,
  input  logic              cfg_load,
  input  logic              cfg_sync,
  input  logic [ACC_W-1:0]  freq_word,
  input  logic [ADDR_W-1:0] phase_off,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] duty,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wave_out,
  output logic              wave_valid,
  output logic              wrap_out
);

  localparam logic [1:0] MODE_SINE = 2'b00;
  localparam logic [1:0] MODE_SAW  = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_SQR  = 2'b11;
  localparam logic [ADDR_W-1:0] DUTY_RST = {1'b1, {(ADDR_W-1){1'b0}}};

  function automatic logic [DATA_W-1:0] saw_map(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: DATA_W];
  endfunction

  // Second half of the phase circle is mirrored so the ramp folds back down.
  function automatic logic [DATA_W-1:0] tri_map(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-2:0] t;
    t = a[ADDR_W-1] ? ~a[ADDR_W-2:0] : a[ADDR_W-2:0];
    return t[ADDR_W-2 -: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] sqr_map(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] d);
    return (a < d) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
  endfunction

  logic [ACC_W-1:0]  act_k_r;
  logic [ADDR_W-1:0] act_p_r;
  logic [1:0]        act_mode_r;
  logic [ADDR_W-1:0] act_duty_r;
  logic [ACC_W-1:0]  shd_k_r;
  logic [ADDR_W-1:0] shd_p_r;
  logic [1:0]        shd_mode_r;
  logic [ADDR_W-1:0] shd_duty_r;
  logic              pend_r;

  logic [ACC_W-1:0]  acc_r;
  logic              wrap_r;
  logic              vld_r;

  logic [ACC_W:0]    sum_s;
  logic              wrap_now_s;
  logic              apply_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] sample_s;

  logic [ADDR_W-1:0] stg_addr_r [0:ROM_LAT];
  logic [1:0]        stg_mode_r [0:ROM_LAT];
  logic [ADDR_W-1:0] stg_duty_r [0:ROM_LAT];
  logic              stg_vld_r  [0:ROM_LAT];
  logic              stg_wrap_r [0:ROM_LAT];

  // Accumulator sum, wrap detection and pending-config apply decision.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, act_k_r};
    wrap_now_s = 1'b0;
    apply_s    = 1'b0;
    if (en && !acc_clr) begin
      wrap_now_s = sum_s[ACC_W];
    end else begin
      wrap_now_s = 1'b0;
    end
    // A load in the same cycle as the wrap defers the apply to the next wrap.
    if (pend_r && wrap_now_s && !cfg_load) begin
      apply_s = 1'b1;
    end else begin
      apply_s = 1'b0;
    end
  end

  // Phase code from the registered accumulator and active offset.
  always_comb begin
    addr_s = acc_r[ACC_W-1 -: ADDR_W] + act_p_r;
  end

  // Active/shadow configuration registers and pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_k_r    <= '0;
      act_p_r    <= '0;
      act_mode_r <= 2'b00;
      act_duty_r <= DUTY_RST;
      shd_k_r    <= '0;
      shd_p_r    <= '0;
      shd_mode_r <= 2'b00;
      shd_duty_r <= DUTY_RST;
      pend_r     <= 1'b0;
    end else if (cfg_load && !cfg_sync) begin
      act_k_r    <= freq_word;
      act_p_r    <= phase_off;
      act_mode_r <= mode;
      act_duty_r <= duty;
      pend_r     <= 1'b0;
    end else if (cfg_load) begin
      shd_k_r    <= freq_word;
      shd_p_r    <= phase_off;
      shd_mode_r <= mode;
      shd_duty_r <= duty;
      pend_r     <= 1'b1;
    end else if (apply_s) begin
      act_k_r    <= shd_k_r;
      act_p_r    <= shd_p_r;
      act_mode_r <= shd_mode_r;
      act_duty_r <= shd_duty_r;
      pend_r     <= 1'b0;
    end
  end

  // Phase accumulator with wrap flag and sample-issue valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= '0;
      wrap_r <= 1'b0;
      vld_r  <= 1'b0;
    end else begin
      vld_r <= en;
      if (acc_clr) begin
        acc_r  <= '0;
        wrap_r <= 1'b0;
      end else if (en) begin
        acc_r  <= sum_s[ACC_W-1:0];
        wrap_r <= sum_s[ACC_W];
      end else begin
        wrap_r <= 1'b0;
      end
    end
  end

  // ROM address issue and delay line matching the external ROM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        stg_addr_r[i] <= '0;
        stg_mode_r[i] <= 2'b00;
        stg_duty_r[i] <= '0;
        stg_vld_r[i]  <= 1'b0;
        stg_wrap_r[i] <= 1'b0;
      end
    end else begin
      rom_addr      <= addr_s;
      stg_addr_r[0] <= addr_s;
      stg_mode_r[0] <= act_mode_r;
      stg_duty_r[0] <= act_duty_r;
      stg_vld_r[0]  <= vld_r;
      stg_wrap_r[0] <= wrap_r;
      for (int i = 1; i <= ROM_LAT; i++) begin
        stg_addr_r[i] <= stg_addr_r[i-1];
        stg_mode_r[i] <= stg_mode_r[i-1];
        stg_duty_r[i] <= stg_duty_r[i-1];
        stg_vld_r[i]  <= stg_vld_r[i-1];
        stg_wrap_r[i] <= stg_wrap_r[i-1];
      end
    end
  end

  // Waveform selection using the mode the sample was issued with.
  always_comb begin
    sample_s = '0;
    case (stg_mode_r[ROM_LAT])
      MODE_SINE: sample_s = rom_data;
      MODE_SAW:  sample_s = saw_map(stg_addr_r[ROM_LAT]);
      MODE_TRI:  sample_s = tri_map(stg_addr_r[ROM_LAT]);
      MODE_SQR:  sample_s = sqr_map(stg_addr_r[ROM_LAT], stg_duty_r[ROM_LAT]);
      default:   sample_s = '0;
    endcase
  end

  // Output register: sample holds between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      wave_out   <= '0;
      wave_valid <= 1'b0;
      wrap_out   <= 1'b0;
    end else begin
      wave_valid <= stg_vld_r[ROM_LAT];
      wrap_out   <= stg_wrap_r[ROM_LAT];
      if (stg_vld_r[ROM_LAT]) begin
        wave_out <= sample_s;
      end
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: one instance with ROM_LAT=1, one with
// ROM_LAT=2, sharing stimulus; expected values are hand-derived per step.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst, en, acc_clr, cfg_load, cfg_sync;
  logic [31:0] freq_word;
  logic [10:0] phase_off, duty;
  logic [1:0]  mode;
  logic [10:0] rom_addr1, rom_addr2;
  logic [9:0]  rom_data1, rom_data2, rom_pipe2;
  logic [9:0]  wave1, wave2;
  logic        valid1, valid2, wrap1, wrap2;

  int vectors = 0;
  int miscompares = 0;

  int t5_addr [0:24] = '{0, 512, 1024, 1536, 0, 256, 512, 768, 1024, 1280,
                         1536, 1792, 0, 256, 512, 768, 1024, 1280, 1536, 1792,
                         0, 1024, 0, 1024, 0};

  function automatic logic [9:0] rom_f(input logic [10:0] a);
    return a[9:0] ^ 10'h2A5;
  endfunction

  function automatic int sq_exp(input int a);
    return (a < 1024) ? 1023 : 0;
  endfunction

  function automatic int tri_exp(input int a);
    return (a < 1024) ? a : 2047 - a;
  endfunction

  function automatic int t4_addr(input int e);
    if (e <= 5) return 3 * e;
    else if (e <= 10) return 15;
    else return 3 * (e - 5);
  endfunction

  function automatic logic t4_en(input int e);
    return !(e >= 6 && e <= 10);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data1 <= rom_f(rom_addr1);
    rom_pipe2 <= rom_f(rom_addr2);
    rom_data2 <= rom_pipe2;
  end

  dds_wave_gen #(.ACC_W(32), .ADDR_W(11), .DATA_W(10), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .acc_clr(acc_clr), .cfg_load(cfg_load),
    .cfg_sync(cfg_sync), .freq_word(freq_word), .phase_off(phase_off),
    .mode(mode), .duty(duty), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .wave_out(wave1), .wave_valid(valid1), .wrap_out(wrap1)
  );

  dds_wave_gen #(.ACC_W(32), .ADDR_W(11), .DATA_W(10), .ROM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .acc_clr(acc_clr), .cfg_load(cfg_load),
    .cfg_sync(cfg_sync), .freq_word(freq_word), .phase_off(phase_off),
    .mode(mode), .duty(duty), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .wave_out(wave2), .wave_valid(valid2), .wrap_out(wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [31:0] k, input logic [10:0] p,
                         input logic [1:0] m, input logic [10:0] d, input logic s);
    freq_word = k;
    phase_off = p;
    mode      = m;
    duty      = d;
    cfg_sync  = s;
    cfg_load  = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; acc_clr = 1'b0;
    set_cfg(32'h0020_0000, 11'd0, 2'b01, 11'd1024, 1'b0);

    // Reset held for three edges; the load presented meanwhile is ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_rom_addr[%0d]", i), rom_addr1, 0);
      chk($sformatf("rst_valid[%0d]", i), valid1, 0);
      chk($sformatf("rst_wave[%0d]", i), wave1, 0);
      chk($sformatf("rst_wrap[%0d]", i), wrap1, 0);
      chk($sformatf("rst_valid2[%0d]", i), valid2, 0);
    end

    // Sawtooth after reset release: sample k has addr k, output addr>>1.
    rst = 1'b0;
    for (int k = 0; k <= 2055; k++) begin
      tick();
      cfg_load = 1'b0;
      chk($sformatf("saw_rom_addr[%0d]", k), rom_addr1, (k == 0) ? 0 : (k - 1) % 2048);
      if (k >= 3) begin
        chk($sformatf("saw_valid[%0d]", k), valid1, 1);
        chk($sformatf("saw_wave[%0d]", k), wave1, ((k - 3) % 2048) >> 1);
        chk($sformatf("saw_wrap[%0d]", k), wrap1, ((k - 3) == 2048) ? 1 : 0);
      end else begin
        chk($sformatf("saw_valid[%0d]", k), valid1, 0);
        chk($sformatf("saw_wave[%0d]", k), wave1, 0);
      end
      if (k >= 4) begin
        chk($sformatf("saw_valid2[%0d]", k), valid2, 1);
        chk($sformatf("saw_wave2[%0d]", k), wave2, ((k - 4) % 2048) >> 1);
        chk($sformatf("saw_wrap2[%0d]", k), wrap2, ((k - 4) == 2048) ? 1 : 0);
      end else begin
        chk($sformatf("saw_valid2[%0d]", k), valid2, 0);
      end
    end

    // Square from a cleared phase, step 128; switch to triangle at sample 12.
    for (int j = 0; j <= 30; j++) begin
      cfg_load = 1'b0; acc_clr = 1'b0;
      if (j == 0) begin
        set_cfg(32'h1000_0000, 11'd0, 2'b11, 11'd1024, 1'b0);
        acc_clr = 1'b1;
      end
      if (j == 12) set_cfg(32'h1000_0000, 11'd0, 2'b10, 11'd1024, 1'b0);
      tick();
      if (j >= 3) begin
        int s, a;
        s = j - 3;
        a = (128 * s) % 2048;
        chk($sformatf("sqtri_valid[%0d]", s), valid1, 1);
        chk($sformatf("sqtri_wave[%0d]", s), wave1, (s < 12) ? sq_exp(a) : tri_exp(a));
        chk($sformatf("sqtri_wrap[%0d]", s), wrap1, (s > 0 && a == 0) ? 1 : 0);
      end
    end

    // Sine through both ROM latencies with en low for five cycles.
    for (int e = 0; e <= 24; e++) begin
      cfg_load = 1'b0; acc_clr = 1'b0;
      if (e == 0) begin
        set_cfg(32'h0060_0000, 11'd0, 2'b00, 11'd1024, 1'b0);
        acc_clr = 1'b1;
      end
      en = t4_en(e);
      tick();
      if (e >= 3) begin
        chk($sformatf("sine_valid[%0d]", e), valid1, t4_en(e - 3));
        chk($sformatf("sine_wave[%0d]", e), wave1, rom_f(11'(t4_addr(e - 3))));
        chk($sformatf("sine_wrap[%0d]", e), wrap1, 0);
      end
      if (e >= 4) begin
        chk($sformatf("sine_valid2[%0d]", e), valid2, t4_en(e - 4));
        chk($sformatf("sine_wave2[%0d]", e), wave2, rom_f(11'(t4_addr(e - 4))));
      end
    end
    en = 1'b1;

    // Wrap-synchronous loads: before a wrap, coincident with a wrap, overwrite.
    for (int e = 0; e <= 27; e++) begin
      cfg_load = 1'b0; acc_clr = 1'b0;
      case (e)
        0: begin
          set_cfg(32'h4000_0000, 11'd0, 2'b01, 11'd1024, 1'b0);
          acc_clr = 1'b1;
        end
        3:  set_cfg(32'h2000_0000, 11'd0, 2'b01, 11'd1024, 1'b1);
        12: set_cfg(32'h4000_0000, 11'd0, 2'b01, 11'd1024, 1'b1);
        14: set_cfg(32'h8000_0000, 11'd0, 2'b01, 11'd1024, 1'b1);
        default: ;
      endcase
      tick();
      if (e >= 3) begin
        int s;
        s = e - 3;
        chk($sformatf("sync_valid[%0d]", s), valid1, 1);
        chk($sformatf("sync_wave[%0d]", s), wave1, t5_addr[s] >> 1);
        chk($sformatf("sync_wrap[%0d]", s), wrap1, (s > 0 && t5_addr[s] == 0) ? 1 : 0);
      end
    end

    // Phase clear with offset 100: next address is 100, sawtooth 50,50,51.
    for (int e = 0; e <= 8; e++) begin
      cfg_load = 1'b0; acc_clr = 1'b0;
      if (e == 0) set_cfg(32'h0020_0000, 11'd100, 2'b01, 11'd1024, 1'b0);
      if (e == 3) acc_clr = 1'b1;
      tick();
      if (e == 4) begin
        chk("clr_rom_addr", rom_addr1, 100);
        chk("clr_rom_addr2", rom_addr2, 100);
      end
      if (e == 6) chk("clr_wave0", wave1, 50);
      if (e == 7) chk("clr_wave1", wave1, 50);
      if (e == 8) chk("clr_wave2", wave1, 51);
    end
    acc_clr = 1'b0;

    // Mid-run reset flushes the pipeline; restart with K=0, sine, P=0.
    rst = 1'b1;
    tick();
    chk("mrst_valid", valid1, 0);
    chk("mrst_wave", wave1, 0);
    chk("mrst_wrap", wrap1, 0);
    chk("mrst_rom_addr", rom_addr1, 0);
    chk("mrst_valid2", valid2, 0);
    chk("mrst_wave2", wave2, 0);
    rst = 1'b0;
    for (int r = 0; r <= 4; r++) begin
      tick();
      chk($sformatf("post_rom_addr[%0d]", r), rom_addr1, 0);
      chk($sformatf("post_valid[%0d]", r), valid1, (r >= 3) ? 1 : 0);
      chk($sformatf("post_wave[%0d]", r), wave1, (r >= 3) ? rom_f(11'd0) : 10'd0);
      chk($sformatf("post_wrap[%0d]", r), wrap1, 0);
      chk($sformatf("post_valid2[%0d]", r), valid2, (r >= 4) ? 1 : 0);
      if (r == 4) chk("post_wave2", wave2, rom_f(11'd0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
